// File: rtl/demux_1_n_stream_pkg.sv
// Shared definitions for the 1:N stream demultiplexer family and its testbenches.
package demux_pkg;

  localparam int DEMUX_DATA_W_DEF = 8;

  // Select width for n channels; a single channel still needs a 1-bit select.
  function automatic int demux_sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_1_n_stream_if.sv
// Stream bundle for demux_1_n_stream: one valid/ready input plus N_OUT valid/ready outputs.
interface demux_1_n_stream_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W_DEF,
  parameter int N_OUT  = 4
);
  localparam int SEL_W = demux_sel_w(N_OUT);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;

  // Demux side: consumes the input stream, produces the channel streams.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_1_n_stream_out_slot.sv
// One-entry registered holding slot for a single demux output channel.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;

  // Stage p1: load wins over drain, so a same-cycle drain+load keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else if (i_load) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= i_data;
    end else if (i_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign o_valid = r_vld_p1;
  assign o_data  = r_data_p1;

endmodule

// File: rtl/demux_1_n_stream.sv
// 1:N valid/ready stream demultiplexer with a registered slot per channel.
// Optional DEMUX_DROP_CNT_EN adds a saturating 8-bit count of out-of-range beats (drop_cnt).
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W_DEF,
  parameter int N_OUT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1_n_stream_if.slave  bus,
  output logic               sel_err
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int SEL_W = demux_sel_w(N_OUT);

  logic [N_OUT-1:0]        w_hit;
  logic [N_OUT-1:0]        w_slot_vld;
  logic [N_OUT-1:0]        w_slot_free;
  logic [N_OUT-1:0]        w_load;
  logic [N_OUT*DATA_W-1:0] w_out_data;
  logic                    w_in_rng;
  logic                    w_drop;
  logic                    r_sel_err;

  // One-hot decode of in_sel; all-zero means the select is out of range.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_hit[i] = (bus.in_sel == SEL_W'(i));
    end
  end

  assign w_in_rng    = |w_hit;
  assign w_slot_free = ~w_slot_vld | bus.out_ready;
  assign bus.in_ready = w_in_rng ? |(w_hit & w_slot_free) : 1'b1;
  assign w_load      = {N_OUT{bus.in_valid}} & w_hit & w_slot_free;
  assign w_drop      = bus.in_valid & ~w_in_rng;

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[g]),
      .i_data  (bus.in_data),
      .i_ready (bus.out_ready[g]),
      .o_valid (w_slot_vld[g]),
      .o_data  (w_out_data[g*DATA_W +: DATA_W])
    );
  end

  assign bus.out_valid = w_slot_vld;
  assign bus.out_data  = w_out_data;

  // Stage p1: sticky error for accepted beats with an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_drop) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Scoreboard bench for demux_1_n_stream with N_OUT=3, so in_sel=3 is out of range.
`timescale 1ns/1ps
module tb_demux_1_n_stream;
  import demux_pkg::*;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 3;
  localparam int SEL_W  = demux_sel_w(N_OUT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_err;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  demux_1_n_stream_if #(.DATA_W(DATA_W), .N_OUT(N_OUT)) bus ();

  demux_1_n_stream #(
    .DATA_W (DATA_W),
    .N_OUT  (N_OUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sel_err  (sel_err)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // Reference model: per-channel FIFO of beats accepted but not yet delivered.
  logic [DATA_W-1:0] exp_q [N_OUT][$];
  logic exp_ready;
  int   push_ch;
  logic oor_now;
  logic err_m;
  int   drop_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch=%0d actual=%0h expected=%0h t=%0t", name, ch, act, exp, $time);
    end
  endtask

  // Drive one clock's worth of stimulus and record what the model says is accepted.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input int s, input logic [N_OUT-1:0] ord);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sel    = SEL_W'(s);
    bus.out_ready = ord;
    if (s >= N_OUT) exp_ready = 1'b1;
    else            exp_ready = (exp_q[s].size() == 0) || ord[s];
    push_ch = -1;
    oor_now = 1'b0;
    if (v && exp_ready) begin
      if (s < N_OUT) begin
        exp_q[s].push_back(d);
        push_ch = s;
      end else begin
        oor_now = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_OUT; i++) exp_q[i].delete();
    exp_ready = 1'b1;
    push_ch   = -1;
    oor_now   = 1'b0;
    err_m     = 1'b0;
    drop_m    = 0;
  endtask

  // Monitor: compares DUT outputs with the model and retires delivered beats.
  always @(negedge clk) begin
    int held;
    if (rst_n) begin
      chk("in_ready", -1, 32'(bus.in_ready), 32'(exp_ready));
      chk("sel_err", -1, 32'(sel_err), 32'(err_m));
`ifdef DEMUX_DROP_CNT_EN
      chk("drop_cnt", -1, 32'(drop_cnt), 32'(drop_m));
`endif
      for (int i = 0; i < N_OUT; i++) begin
        held = exp_q[i].size() - ((push_ch == i) ? 1 : 0);
        chk("out_valid", i, 32'(bus.out_valid[i]), 32'(held > 0));
        if (held > 0) begin
          chk("out_data", i, 32'(bus.out_data[i*DATA_W +: DATA_W]), 32'(exp_q[i][0]));
          if (bus.out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
      if (oor_now) begin
        err_m = 1'b1;
        if (drop_m < 255) drop_m++;
      end
      push_ch = -1;
      oor_now = 1'b0;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.out_ready = '0;
    model_reset();

    #2;
    chk("rst_out_valid", -1, 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", -1, 32'(bus.out_data), 32'd0);
    chk("rst_sel_err", -1, 32'(sel_err), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic routing, every consumer ready.
    for (int i = 0; i < N_OUT; i++) cycle(1'b1, DATA_W'(8'hA0 + i), i, '1);
    repeat (2) cycle(1'b0, '0, 0, '1);

    // Backpressure on channel 2 with a channel-1 beat slipping through.
    cycle(1'b1, 8'hB0, 2, 3'b011);
    cycle(1'b1, 8'hB1, 2, 3'b011);
    cycle(1'b1, 8'hC1, 1, 3'b011);
    cycle(1'b1, 8'hB1, 2, 3'b011);
    cycle(1'b1, 8'hB1, 2, 3'b111);
    repeat (2) cycle(1'b0, '0, 0, '1);

    // Same-cycle drain and load on channel 0.
    cycle(1'b1, 8'h33, 0, 3'b000);
    cycle(1'b0, '0, 0, 3'b000);
    cycle(1'b1, 8'h55, 0, 3'b001);
    cycle(1'b0, '0, 0, 3'b000);
    cycle(1'b0, '0, 0, '1);

    // Out-of-range select: dropped, sel_err sticky.
    cycle(1'b1, 8'hEE, 3, 3'b000);
    repeat (3) cycle(1'b0, '0, 0, 3'b000);

`ifdef DEMUX_DROP_CNT_EN
    repeat (300) cycle(1'b1, DATA_W'($urandom), 3, N_OUT'($urandom));
    cycle(1'b0, '0, 0, '1);
    @(negedge clk);
    chk("drop_cnt_sat", -1, 32'(drop_cnt), 32'd255);
`endif

    // Reset mid-operation with every slot full.
    cycle(1'b1, 8'h10, 0, 3'b000);
    cycle(1'b1, 8'h11, 1, 3'b000);
    cycle(1'b1, 8'h12, 2, 3'b000);
    cycle(1'b0, '0, 0, 3'b000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    model_reset();
    #1;
    chk("mid_rst_out_valid", -1, 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", -1, 32'(bus.out_data), 32'd0);
    chk("mid_rst_sel_err", -1, 32'(sel_err), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < N_OUT; i++) cycle(1'b1, DATA_W'(8'h60 + i), i, '1);
    repeat (2) cycle(1'b0, '0, 0, '1);

    // Randomized traffic including out-of-range selects.
    repeat (1500) begin
      cycle($urandom_range(0, 9) < 7, DATA_W'($urandom), int'($urandom_range(0, 3)), N_OUT'($urandom));
    end
    repeat (3) cycle(1'b0, '0, 0, '1);
    @(negedge clk);
    for (int i = 0; i < N_OUT; i++) chk("drained", i, 32'(exp_q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
